// File: rtl/data_ram_responder.sv
// data_ram_responder
// Word-organised data memory serving load/store requests from the MEM stage.
// Each accepted access spends WAIT_CYCLES wait states in ACCESS and then one
// completion cycle in DONE. The stall request is held high until the access
// completes. Byte lanes are big-endian: sel[3] selects data[31:24].
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   mem_ce_i     request valid, held stable while stalled
//   mem_we_i     1 = store, 0 = load
//   mem_addr_i   byte address; word index = [ADDR_WIDTH+1:2]
//   mem_sel_i    byte-lane enables for stores
//   mem_data_i   store data, already lane-replicated
//   mem_data_o   load data, full word, held until the next completed load
//   stall_req_o  freeze pipeline while the access is in progress
//   ack_o        one-cycle completion pulse
//   err_o        one-cycle pulse with ack_o for an out-of-range address
//
// state  | meaning
// IDLE   | no access in progress
// ACCESS | wait-state countdown; memory operation on the edge where cnt = 0
// DONE   | completion cycle (ack_o/err_o); request on inputs not re-accepted
module data_ram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stall_req_o,
    output logic        ack_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [3:0]              sel_q, sel_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    oor_q, oor_d;
    logic [31:0]             rdata_q;
    logic                    do_op;

    logic [31:0] mem_q [2**ADDR_WIDTH];

    // The operation happens on the edge that leaves ACCESS.
    assign do_op = (state_q == S_ACCESS) && (cnt_q == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            oor_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
            if (do_op && !we_q) begin
                rdata_q <= oor_q ? 32'd0 : mem_q[idx_q];
            end
        end
    end

    // Storage is deliberately not reset; reset on the operation edge still
    // blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && do_op && we_q && !oor_q) begin
            for (int i = 0; i < 4; i++) begin
                if (sel_q[i]) begin
                    mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        case (state_q)
            S_IDLE: begin
                if (mem_ce_i) begin
                    we_d    = mem_we_i;
                    idx_d   = mem_addr_i[ADDR_WIDTH+1:2];
                    sel_d   = mem_sel_i;
                    wdata_d = mem_data_i;
                    oor_d   = (mem_addr_i[31:ADDR_WIDTH+2] != '0);
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        stall_req_o = ((state_q == S_IDLE) && mem_ce_i) || (state_q == S_ACCESS);
        ack_o       = (state_q == S_DONE);
        err_o       = (state_q == S_DONE) && oor_q;
        mem_data_o  = rdata_q;
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder. Two instances share the clock:
// u_dut with WAIT_CYCLES=2 and u_dut0 with WAIT_CYCLES=0.
module tb_data_ram_responder;

    logic        clk;
    logic        rst;

    logic        ce_a, we_a;
    logic [31:0] addr_a, wdat_a;
    logic [3:0]  sel_a;
    logic [31:0] rdat_a;
    logic        stall_a, ack_a, err_a;

    logic        ce_b, we_b;
    logic [31:0] addr_b, wdat_b;
    logic [3:0]  sel_b;
    logic [31:0] rdat_b;
    logic        stall_b, ack_b, err_b;

    int vectors   = 0;
    int miscomp   = 0;
    int cycle     = 0;
    int ack_cyc   = 0;
    int first_ack = 0;

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (ce_a),
        .mem_we_i   (we_a),
        .mem_addr_i (addr_a),
        .mem_sel_i  (sel_a),
        .mem_data_i (wdat_a),
        .mem_data_o (rdat_a),
        .stall_req_o(stall_a),
        .ack_o      (ack_a),
        .err_o      (err_a)
    );

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (ce_b),
        .mem_we_i   (we_b),
        .mem_addr_i (addr_b),
        .mem_sel_i  (sel_b),
        .mem_data_i (wdat_b),
        .mem_data_o (rdat_b),
        .stall_req_o(stall_b),
        .ack_o      (ack_b),
        .err_o      (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscomp++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Runs one access starting at the beginning of the current cycle
    // (called #1 after a rising edge). Returns at the start of the cycle
    // after DONE; ce stays high when keep_ce is set.
    task automatic access(input bit d0, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input bit keep_ce, input string tag);
        int  stalls = 0;
        bit  acked  = 0;
        int  exp_st = d0 ? 2 : 4;
        logic st, ak, er;
        logic [31:0] rd;
        if (d0) begin
            ce_b = 1'b1; we_b = we; addr_b = addr; sel_b = sel; wdat_b = wd;
        end else begin
            ce_a = 1'b1; we_a = we; addr_a = addr; sel_a = sel; wdat_a = wd;
        end
        for (int k = 0; k < 20 && !acked; k++) begin
            @(negedge clk);
            st = d0 ? stall_b : stall_a;
            ak = d0 ? ack_b   : ack_a;
            er = d0 ? err_b   : err_a;
            rd = d0 ? rdat_b  : rdat_a;
            if (ak) begin
                acked   = 1;
                ack_cyc = cycle;
                check({tag, "_stall_at_ack"}, {31'd0, st}, 32'd0);
                check({tag, "_err"},          {31'd0, er}, {31'd0, exp_err});
                if (!we) check({tag, "_rdata"}, rd, exp_rd);
            end else begin
                if (st) stalls++;
            end
            @(posedge clk); #1;
        end
        check({tag, "_acked"},  {31'd0, acked}, 32'd1);
        check({tag, "_stalls"}, stalls, exp_st);
        if (!keep_ce) begin
            if (d0) ce_b = 1'b0; else ce_a = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        ce_a = 0; we_a = 0; addr_a = 0; sel_a = 0; wdat_a = 0;
        ce_b = 0; we_b = 0; addr_b = 0; sel_b = 0; wdat_b = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'd0, stall_a}, 32'd0);
        check("rst_ack",   {31'd0, ack_a},   32'd0);
        check("rst_err",   {31'd0, err_a},   32'd0);
        check("rst_rdata", rdat_a,           32'd0);
        check("rst0_stall", {31'd0, stall_b}, 32'd0);
        check("rst0_rdata", rdat_b,           32'd0);
        @(posedge clk); #1;

        // Full-word store then load
        access(0, 1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 0, "st10");
        access(0, 0, 32'h10, 4'b0000, 32'h0, 32'hDEADBEEF, 0, 0, "ld10");

        // Single byte lane (big-endian lane 2 = data[23:16])
        access(0, 1, 32'h10, 4'b0100, 32'h12121212, 32'h0, 0, 0, "stb10");
        access(0, 0, 32'h10, 4'b0000, 32'h0, 32'hDE12BEEF, 0, 0, "ldb10");

        // Back-to-back loads with ce held
        access(0, 1, 32'h0, 4'b1111, 32'h01234567, 32'h0, 0, 0, "st0");
        access(0, 1, 32'h4, 4'b1111, 32'h89ABCDEF, 32'h0, 0, 0, "st4");
        access(0, 0, 32'h0, 4'b0000, 32'h0, 32'h01234567, 0, 1, "bb0");
        first_ack = ack_cyc;
        access(0, 0, 32'h4, 4'b0000, 32'h0, 32'h89ABCDEF, 0, 0, "bb4");
        check("bb_spacing", ack_cyc - first_ack, 32'd5);
        @(negedge clk);
        check("bb_no_dup_ack",   {31'd0, ack_a},   32'd0);
        check("bb_no_dup_stall", {31'd0, stall_a}, 32'd0);
        @(posedge clk); #1;

        // Out of range: word index aliases word 0 if not suppressed
        access(0, 1, 32'h00010000, 4'b1111, 32'hFFFFFFFF, 32'h0, 1, 0, "oor_st");
        access(0, 0, 32'h0, 4'b0000, 32'h0, 32'h01234567, 0, 0, "ld0_after_oor");
        access(0, 0, 32'h00010004, 4'b0000, 32'h0, 32'h0, 1, 0, "oor_ld");

        // Reset in the second stall cycle of a store
        access(0, 1, 32'h20, 4'b1111, 32'hCAFEF00D, 32'h0, 0, 0, "st20");
        access(0, 0, 32'h20, 4'b0000, 32'h0, 32'hCAFEF00D, 0, 0, "ld20");
        ce_a = 1; we_a = 1; addr_a = 32'h20; sel_a = 4'b1111; wdat_a = 32'h11111111;
        @(negedge clk);
        check("abort_stall1", {31'd0, stall_a}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ce_a = 0;
        @(negedge clk);
        check("abort_stall", {31'd0, stall_a}, 32'd0);
        check("abort_ack",   {31'd0, ack_a},   32'd0);
        check("abort_err",   {31'd0, err_a},   32'd0);
        check("abort_rdata", rdat_a,           32'd0);
        @(posedge clk); #1;
        access(0, 0, 32'h20, 4'b0000, 32'h0, 32'hCAFEF00D, 0, 0, "ld20_after_abort");

        // WAIT_CYCLES=0 instance, empty byte mask
        access(1, 1, 32'h8, 4'b1111, 32'h55AA55AA, 32'h0, 0, 0, "w0_st8");
        access(1, 1, 32'h8, 4'b0000, 32'hFFFFFFFF, 32'h0, 0, 0, "w0_sel0");
        access(1, 0, 32'h8, 4'b0000, 32'h0, 32'h55AA55AA, 0, 0, "w0_ld8");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

Word-organised data memory that answers the load/store requests issued by the MEM pipeline stage (address, write-enable, byte-select, write data, chip-enable). It adds a fixed number of wait states and raises a stall request to the pipeline controller until the access completes. Byte lanes are big-endian: `sel[3]` selects `data[31:24]`, which is byte address `…00`. It sits between the MEM stage and the data-side storage.

## Interface
- `ADDR_WIDTH`, 10: word-address width; depth is 2^ADDR_WIDTH words.
- `WAIT_CYCLES`, 2: extra wait states per access (0..15).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `mem_ce_i`  in  1  request valid; held stable by the pipeline while stalled.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_addr_i`  in  32  byte address; word index = `[ADDR_WIDTH+1:2]`; `[1:0]` ignored.
- `mem_sel_i`  in  4  byte-lane enables for stores (big-endian).
- `mem_data_i`  in  32  store data, already lane-replicated by the MEM stage.
- `mem_data_o`  out  32  load data, full word; the MEM stage extracts bytes or halfwords.
- `stall_req_o`  out  1  freeze pipeline while the access is in progress.
- `ack_o`  out  1  one-cycle pulse marking access completion.
- `err_o`  out  1  one-cycle pulse with `ack_o` when the address is out of range.

## Operation
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: wait-state counting, then the memory operation.
  - DONE: completion cycle.
- IDLE:
  - `mem_ce_i`=1: latch `we`, `addr`, `sel`, `data` and the range check; load `cnt` = WAIT_CYCLES; go to ACCESS.
  - `mem_ce_i`=0: stay in IDLE.
- ACCESS:
  - `cnt`≠0: decrement `cnt`; stay in ACCESS.
  - `cnt`=0: perform the operation at this edge; go to DONE.
- DONE: go to IDLE unconditionally. The request still visible on the inputs in this cycle is not re-accepted, because the pipeline advances at the end of DONE.
- Stall: `stall_req_o` = (IDLE && `mem_ce_i`) || ACCESS. This is combinational, so the stall is raised in the same cycle the request appears.
- Store: for each i with `sel[i]`=1, write `mem[idx][8i+7:8i]` <= `data[8i+7:8i]`.
  - Unselected bytes are unchanged.
  - `sel`=0000 writes nothing but still completes and acks.
- Load: `mem_data_o` <= `mem[idx]` (full word, `sel` ignored).
  - `mem_data_o` holds its value until the next completed load.
  - Stores do not change `mem_data_o`.
- Out of range (`addr[31:ADDR_WIDTH+2]`≠0):
  - store: suppressed;
  - load: returns 32'h0;
  - `err_o`=1 in DONE.
- Memory array is not reset; contents survive `rst`.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0;
  - `mem_data_o` = 0, `ack_o` = 0, `err_o` = 0;
  - `stall_req_o` = 0 after reset (`rst` forces IDLE; the stall term then follows `mem_ce_i`).
- Request accepted in cycle T0:
  - `stall_req_o` is high for cycles T0 .. T0+WAIT_CYCLES+1, i.e. WAIT_CYCLES+2 cycles.
  - DONE occurs in cycle T0+WAIT_CYCLES+2 with `stall_req_o`=0, `ack_o`=1, and `mem_data_o` valid (loads).
- Throughput: back-to-back requests start at T0+WAIT_CYCLES+3, one access per WAIT_CYCLES+3 cycles.
- WAIT_CYCLES=0: stall for 2 cycles, ack in T0+2.
- Reset during ACCESS before the operation edge: the access is aborted, no write occurs, and `mem_data_o` = 0.
- Reset in the same edge as the operation: reset wins and no write occurs.
- `mem_ce_i` dropping during ACCESS is a protocol violation; the latched request completes regardless.

## Test plan
- Reset, then WAIT_CYCLES=2 store to addr 0x10 with sel=1111, data 0xDEADBEEF:
  - stall high for 4 cycles, ack in cycle 4;
  - a load from 0x10 then returns 0xDEADBEEF with ack in its cycle 4.
- Byte store to 0x10 with sel=0100 and data 0x12121212, over 0xDEADBEEF:
  - a subsequent load returns 0xDE12BEEF.
- Back-to-back loads from 0x0 and 0x4 (ce held, addr changed in the cycle after DONE):
  - two acks spaced 5 cycles apart, each returning the correct word;
  - no duplicate access.
- Out-of-range store to 0x00010000 (ADDR_WIDTH=10):
  - err_o and ack pulse together;
  - a following load from 0x0 shows the word unchanged;
  - an out-of-range load returns 0.
- `rst` asserted during the 2nd stall cycle of a store to 0x20:
  - all outputs return to their reset values next cycle;
  - a later load from 0x20 shows the old contents.
- WAIT_CYCLES=0, store with sel=0000:
  - stall for 2 cycles, ack, memory unchanged.
